// File: rtl/uart_frame_arbiter.sv
// Round-robin arbiter sharing one FRAME_W-bit UART frame sender between NREQ producers.
// Optional send timeout/abort is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_frame_arbiter #(
  parameter int          NREQ        = 2,
  parameter int          FRAME_W     = 320,
  parameter int unsigned TIMEOUT_CYC = 50000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*FRAME_W-1:0] req_data,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         ack,
  output logic [NREQ-1:0]         err,
  output logic                    busy,
  output logic                    send,
  output logic [FRAME_W-1:0]      data,
  input  logic                    send_done
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t             state_reg, state_next;
  logic [NREQ-1:0]    grant_reg, grant_next;
  logic [NREQ-1:0]    ack_reg, ack_next;
  logic               send_reg, send_next;
  logic [FRAME_W-1:0] data_reg, data_next;
  logic [LW-1:0]      last_reg, last_next;
  logic [LW-1:0]      win_reg, win_next;
  logic [LW-1:0]      pick_idx;
  logic               pick_valid;

  logic [FRAME_W-1:0] slice [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign slice[gi] = req_data[gi*FRAME_W +: FRAME_W];
    end
  endgenerate

  // First pending requester after the last winner, wrapping modulo NREQ.
  always_comb begin
    int idx;
    idx        = 0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_reg) + k) % NREQ;
      if (!pick_valid && req[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = LW'(idx);
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  logic [31:0]     cnt_reg, cnt_next;
  logic [NREQ-1:0] err_reg, err_next;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    ack_next   = '0;
    send_next  = send_reg;
    data_next  = data_reg;
    last_next  = last_reg;
    win_next   = win_reg;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_next   = cnt_reg;
    err_next   = '0;
`endif
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          grant_next = NREQ'(1) << pick_idx;
          data_next  = slice[pick_idx];
          win_next   = pick_idx;
          send_next  = 1'b1;
          state_next = SEND;
`ifdef UART_ARB_TIMEOUT_EN
          cnt_next   = '0;
`endif
        end
      end
      SEND: begin
`ifdef UART_ARB_TIMEOUT_EN
        cnt_next = cnt_reg + 32'd1;
`endif
        if (send_done) begin
          send_next  = 1'b0;
          ack_next   = grant_reg;
          grant_next = '0;
          last_next  = win_reg;
          state_next = GAP;
        end
`ifdef UART_ARB_TIMEOUT_EN
        // send_done in the same cycle wins over the abort.
        else if (cnt_reg == TIMEOUT_CYC - 1) begin
          send_next  = 1'b0;
          err_next   = grant_reg;
          grant_next = '0;
          last_next  = win_reg;
          state_next = GAP;
        end
`endif
      end
      GAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        send_next  = 1'b0;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      ack_reg   <= '0;
      send_reg  <= 1'b0;
      data_reg  <= '0;
      last_reg  <= LW'(NREQ - 1);
      win_reg   <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_reg   <= '0;
      err_reg   <= '0;
`endif
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      ack_reg   <= ack_next;
      send_reg  <= send_next;
      data_reg  <= data_next;
      last_reg  <= last_next;
      win_reg   <= win_next;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
`endif
    end
  end

  assign grant = grant_reg;
  assign ack   = ack_reg;
  assign send  = send_reg;
  assign data  = data_reg;
  assign busy  = (state_reg != IDLE);
`ifdef UART_ARB_TIMEOUT_EN
  assign err   = err_reg;
`else
  assign err   = '0;
`endif

endmodule
